mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have clock  input  1  rising-edge clock for all state.
REQ-002 SHALL have clear  input  1  asynchronous, active-high reset.
REQ-003 SHALL have start  input  1  request; sampled only when state is IDLE or DONE.
REQ-004 SHALL have multiplier  input  32  signed two's-complement operand; captured on accepted start.
REQ-005 SHALL have multiplicand  input  32  signed two's-complement operand; captured on accepted start.
REQ-006 SHALL have busy  output  1  high while state is RUN.
REQ-007 SHALL have done  output  1  single-cycle pulse; high while state is DONE.
REQ-008 SHALL have ansHI  output  32  registered upper word of the last completed product.
REQ-009 SHALL have ansLO  output  32  registered lower word of the last completed product.

Function
REQ-010 SHALL implement states IDLE, RUN and DONE.
REQ-011 IDLE: start=1 -> capture both operands, clear the 64-bit accumulator, step counter=0, go to RUN; start=0 -> stay in IDLE.
REQ-012 RUN: perform one radix-4 Booth step per cycle for exactly 16 cycles (counter 0..15), then go to DONE.
REQ-013 Step i: digit from triplet {mr[2i+1], mr[2i], mr[2i-1]}, with mr[-1]=0.
REQ-014 Digit map: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
REQ-015 Each step: sign-extend the digit-selected multiplicand to 64 bits, shift left by 2i, and add it to the accumulator modulo 2^64.
REQ-016 The result SHALL be the exact signed 64-bit product for all operand pairs, including -2^31 x -2^31 = 2^62.
REQ-017 Internal +2M/-2M SHALL use at least 34 bits before sign extension so that no overflow occurs.
REQ-018 On entry to DONE, ansHI/ansLO SHALL load accumulator[63:32]/[31:0].
REQ-019 ansHI/ansLO SHALL hold their value until the next DONE entry; they SHALL NOT change during RUN.
REQ-020 Latency: start accepted at edge N -> done high in the cycle after edge N+16; results are valid in that same cycle.
REQ-021 DONE lasts exactly one cycle: start=1 -> accept new operands and go to RUN (back-to-back); else go to IDLE.
REQ-022 start during RUN SHALL be ignored; the captured operands SHALL remain unchanged and no request is queued.
REQ-023 Operand input changes after acceptance SHALL NOT affect the result in flight.
REQ-024 busy and done SHALL never be high simultaneously.

Reset
REQ-025 clear=1 SHALL immediately force state=IDLE, busy=0, done=0, ansHI=0, ansLO=0, counter=0, accumulator=0.
REQ-026 clear asserted during RUN SHALL abort the operation; no done pulse and no HI/LO update follow.
REQ-027 After clear deasserts, the first accepted start SHALL behave exactly as after power-up.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10), STEPS=16 and the operand width of 32.
REQ-029 Radix-4 recoding SHALL be a combinational sub-module booth_digit_sel: 3-bit triplet in; select {zero, one, two, neg} out.
REQ-030 The top level SHALL contain the FSM, step counter, operand registers, accumulator and adder; it SHALL contain no clock gating and no combinational path from start to done.

Verification
REQ-031 3 x 5 -> after 16 busy cycles, done pulses once; ansHI=0x00000000, ansLO=0x0000000F.
REQ-032 7 (multiplier) x -2 -> ansHI=0xFFFFFFFF, ansLO=0xFFFFFFF2; 0xFFFFFFFF x 0xFFFFFFFF -> ansHI=0, ansLO=1.
REQ-033 0x80000000 x 0x80000000 -> ansHI=0x40000000, ansLO=0x00000000; 0x7FFFFFFF x 0x80000000 -> ansHI=0xC0000000, ansLO=0x80000000.
REQ-034 Start 3x5; in RUN cycle 4 pulse start with 9x9 -> result 15 only, single done pulse, busy stays 16 cycles.
REQ-035 Start 3x5; assert clear in RUN cycle 8 -> busy=0, HI/LO=0 at once, no done; then 2x2 -> ansLO=4 after 16 cycles.
REQ-036 Back-to-back: start held high -> done every 17 cycles, HI/LO updating per operand pair, busy low only during done cycles.

Source files
------------

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared constants for the sequential radix-4 Booth multiplier controller.
package mul_seq_ctrl_pkg;

    localparam int WIDTH     = 32;
    localparam int STEPS     = 16;
    localparam int STEP_W    = $clog2(STEPS);
    localparam int ACC_W     = 2 * WIDTH;
    localparam int PP_W      = WIDTH + 2;
    localparam int TRIPLET_W = 3;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/mul_seq_ctrl_booth.sv
// Radix-4 Booth recoder: maps a multiplier bit triplet to a {zero, one, two, neg} select.
module booth_digit_sel
    import mul_seq_ctrl_pkg::*;
(
    input  logic [TRIPLET_W-1:0] triplet,
    output logic                 zero,
    output logic                 one,
    output logic                 two,
    output logic                 neg
);

    always_comb begin
        zero = 1'b0;
        one  = 1'b0;
        two  = 1'b0;
        neg  = 1'b0;
        case (triplet)
            3'b001, 3'b010: one = 1'b1;
            3'b011:         two = 1'b1;
            3'b100: begin
                two = 1'b1;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                one = 1'b1;
                neg = 1'b1;
            end
            default:        zero = 1'b1;
        endcase
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential signed 32x32 multiplier: one radix-4 Booth step per cycle, 16 steps per product.
//
// state | meaning
// IDLE  | waiting for start; operands and result held
// RUN   | one Booth step per cycle, step counter 0..15
// DONE  | one-cycle result pulse; start here chains the next product
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplier,
    input  logic [WIDTH-1:0] multiplicand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ansHI,
    output logic [WIDTH-1:0] ansLO
);

    localparam int IDX_W = $clog2(WIDTH + 1);

    logic [1:0]           state;
    logic [STEP_W-1:0]    step;
    logic [WIDTH-1:0]     mr_q;
    logic [WIDTH-1:0]     md_q;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     ans_q;

    logic [WIDTH:0]       mr_ext;
    logic [IDX_W-1:0]     bit_idx;
    logic [TRIPLET_W-1:0] triplet;
    logic                 sel_zero;
    logic                 sel_one;
    logic                 sel_two;
    logic                 sel_neg;
    logic [PP_W-1:0]      mag;
    logic [PP_W-1:0]      pp;
    logic [ACC_W-1:0]     pp_ext;
    logic [ACC_W-1:0]     addend;
    logic [ACC_W-1:0]     acc_next;
    logic                 last_step;

    // mr[-1] is the appended zero, so triplet i sits at bit 2i of mr_ext
    assign mr_ext  = {mr_q, 1'b0};
    assign bit_idx = IDX_W'(step) << 1;
    assign triplet = mr_ext[bit_idx +: TRIPLET_W];

    booth_digit_sel u_digit (
        .triplet (triplet),
        .zero    (sel_zero),
        .one     (sel_one),
        .two     (sel_two),
        .neg     (sel_neg)
    );

    // 34-bit partial product keeps -2 x -2^31 and its negation in range
    always_comb begin
        mag = '0;
        if (sel_two) begin
            mag = {md_q[WIDTH-1], md_q, 1'b0};
        end else if (sel_one) begin
            mag = {{2{md_q[WIDTH-1]}}, md_q};
        end
    end

    assign pp        = sel_zero ? '0 : (sel_neg ? (~mag + 1'b1) : mag);
    assign pp_ext    = {{(ACC_W - PP_W){pp[PP_W-1]}}, pp};
    assign addend    = pp_ext << bit_idx;
    assign acc_next  = acc + addend;
    assign last_step = (step == STEP_W'(STEPS - 1));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
            step  <= '0;
            mr_q  <= '0;
            md_q  <= '0;
            acc   <= '0;
            ans_q <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    step <= '0;
                    if (start) begin
                        mr_q  <= multiplier;
                        md_q  <= multiplicand;
                        acc   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc  <= acc_next;
                    step <= step + 1'b1;
                    if (last_step) begin
                        ans_q <= acc_next;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);
    assign ansHI = ans_q[ACC_W-1:WIDTH];
    assign ansLO = ans_q[WIDTH-1:0];

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl against a plain 64-bit signed multiply model.
module tb_mul_seq_ctrl;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] multiplier;
    logic [31:0] multiplicand;
    logic        busy;
    logic        done;
    logic [31:0] ansHI;
    logic [31:0] ansLO;

    int tests_run    = 0;
    int tests_failed = 0;
    int overlap      = 0;

    mul_seq_ctrl dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .busy         (busy),
        .done         (done),
        .ansHI        (ansHI),
        .ansLO        (ansLO)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (busy && done) overlap++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [6];
        corners = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                    32'h8000_0000, 32'h7FFF_FFFF, 32'hAAAA_5555};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    // Drives one product from IDLE, scrambles operands after acceptance, reports what it saw.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int busy_cnt, output int done_cyc,
                         output bit ans_moved, output bit done_after);
        logic [63:0] ans0;
        @(negedge clock);
        multiplier   = a;
        multiplicand = b;
        start        = 1'b1;
        @(posedge clock); #1;
        start        = 1'b0;
        multiplier   = $urandom;
        multiplicand = $urandom;
        ans0       = {ansHI, ansLO};
        busy_cnt   = 0;
        done_cyc   = 0;
        ans_moved  = 1'b0;
        done_after = 1'b0;
        res        = '0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                done_cyc = c;
                res      = {ansHI, ansLO};
                break;
            end
            if (busy) busy_cnt++;
            if ({ansHI, ansLO} !== ans0) ans_moved = 1'b1;
            @(posedge clock); #1;
        end
        if (done_cyc != 0) begin
            @(posedge clock); #1;
            done_after = done;
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        start = 1'b0;
        multiplier   = '0;
        multiplicand = '0;
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if ({busy, done, ansHI, ansLO} !== 66'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, ansHI, ansLO);
        end
        @(negedge clock);
        clear = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [63:0] ve [5];
        logic [63:0] res;
        int bc, dc;
        bit moved, da;
        va = '{32'd3, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        vb = '{32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        ve = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFF_FFFF_FFF2, 64'h0000_0000_0000_0001,
               64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000};
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], res, bc, dc, moved, da);
            tests_run++;
            if (res !== ve[i]) begin
                tests_failed++;
                $display("FAIL directed_%0d: got %h, required %h", i, res, ve[i]);
            end
            tests_run++;
            if (bc !== 16 || dc !== 17 || da !== 1'b0) begin
                tests_failed++;
                $display("FAIL directed_timing_%0d: busy=%0d done_cycle=%0d done_next=%b, required 16 17 0", i, bc, dc, da);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [63:0] res, exp;
        int bc, dc;
        bit moved, da;
        for (int i = 0; i < 24; i++) begin
            a   = pick_operand();
            b   = pick_operand();
            exp = ref_mul(a, b);
            do_op(a, b, res, bc, dc, moved, da);
            tests_run++;
            if (res !== exp) begin
                tests_failed++;
                $display("FAIL random_%0d: %h x %h got %h, required %h", i, a, b, res, exp);
            end
            tests_run++;
            if (bc !== 16 || dc !== 17 || da !== 1'b0 || moved !== 1'b0) begin
                tests_failed++;
                $display("FAIL random_timing_%0d: busy=%0d done_cycle=%0d done_next=%b ans_moved=%b, required 16 17 0 0", i, bc, dc, da, moved);
            end
        end
    endtask

    task automatic test_start_ignored();
        int bc = 0;
        int dn = 0;
        logic [63:0] res = '0;
        @(negedge clock);
        multiplier   = 32'd3;
        multiplicand = 32'd5;
        start        = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) bc++;
            if (done) begin
                dn++;
                res = {ansHI, ansLO};
            end
            @(negedge clock);
            start = (c == 4);
            if (c == 4) begin
                multiplier   = 32'd9;
                multiplicand = 32'd9;
            end
            @(posedge clock); #1;
        end
        tests_run++;
        if (dn !== 1 || bc !== 16) begin
            tests_failed++;
            $display("FAIL start_ignored_pulses: done=%0d busy=%0d, required 1 16", dn, bc);
        end
        tests_run++;
        if (res !== 64'd15) begin
            tests_failed++;
            $display("FAIL start_ignored_result: got %h, required %h", res, 64'd15);
        end
    endtask

    task automatic test_clear_abort();
        logic [63:0] res;
        int bc, dc;
        bit moved, da;
        int seen_done = 0;
        int seen_busy = 0;
        do_op(32'd6, 32'd7, res, bc, dc, moved, da);
        tests_run++;
        if (res !== 64'd42) begin
            tests_failed++;
            $display("FAIL clear_preload: got %h, required %h", res, 64'd42);
        end
        @(negedge clock);
        multiplier   = 32'd3;
        multiplicand = 32'd5;
        start        = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (7) @(posedge clock);
        #3;
        clear = 1'b1;
        #1;
        tests_run++;
        if ({busy, done, ansHI, ansLO} !== 66'd0) begin
            tests_failed++;
            $display("FAIL clear_abort_now: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, ansHI, ansLO);
        end
        @(negedge clock);
        clear = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clock); #1;
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        tests_run++;
        if (seen_done !== 0 || seen_busy !== 0) begin
            tests_failed++;
            $display("FAIL clear_no_done: done=%0d busy=%0d, required 0 0", seen_done, seen_busy);
        end
        do_op(32'd2, 32'd2, res, bc, dc, moved, da);
        tests_run++;
        if (res !== 64'd4 || dc !== 17 || bc !== 16) begin
            tests_failed++;
            $display("FAIL clear_restart: got %h done_cycle=%0d busy=%0d, required 4 17 16", res, dc, bc);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 5;
        logic [31:0] pa [N];
        logic [31:0] pb [N];
        logic [63:0] res [N];
        int dcyc [N];
        int nd = 0;
        int gaps = 0;
        for (int i = 0; i < N; i++) begin
            pa[i] = pick_operand();
            pb[i] = pick_operand();
            res[i]  = '0;
            dcyc[i] = 0;
        end
        @(negedge clock);
        multiplier   = pa[0];
        multiplicand = pb[0];
        start        = 1'b1;
        for (int c = 1; c <= N * 17 + 10; c++) begin
            @(posedge clock); #1;
            if (nd < N && c > 1 && !busy && !done) gaps++;
            if (done && nd < N) begin
                res[nd]  = {ansHI, ansLO};
                dcyc[nd] = c;
                nd++;
                @(negedge clock);
                if (nd < N) begin
                    multiplier   = pa[nd];
                    multiplicand = pb[nd];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        tests_run++;
        if (nd !== N || gaps !== 0) begin
            tests_failed++;
            $display("FAIL b2b_count: dones=%0d idle_gaps=%0d, required %0d 0", nd, gaps, N);
        end
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (res[i] !== ref_mul(pa[i], pb[i]) || dcyc[i] !== 17 * (i + 1)) begin
                tests_failed++;
                $display("FAIL b2b_%0d: got %h at cycle %0d, required %h at cycle %0d",
                         i, res[i], dcyc[i], ref_mul(pa[i], pb[i]), 17 * (i + 1));
            end
        end
        tests_run++;
        if (overlap !== 0) begin
            tests_failed++;
            $display("FAIL busy_done_overlap: got %0d cycles, required 0", overlap);
        end
    endtask

    initial begin
        clear        = 1'b1;
        start        = 1'b0;
        multiplier   = '0;
        multiplicand = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_clear_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
